// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants: op-index enumeration, major opcodes,
// funct3/funct7 values and a per-op lookup used by both encode and decode.
package instr_encoder_pkg;

    // Op index enumeration shared with the decode stage; indices 37..63 are undefined.
    typedef enum logic [5:0] {
        OP_ADD   = 6'd0,  OP_SUB   = 6'd1,  OP_SLL   = 6'd2,  OP_SLT   = 6'd3,
        OP_SLTU  = 6'd4,  OP_XOR   = 6'd5,  OP_SRL   = 6'd6,  OP_SRA   = 6'd7,
        OP_OR    = 6'd8,  OP_AND   = 6'd9,
        OP_ADDI  = 6'd10, OP_SLTI  = 6'd11, OP_SLTIU = 6'd12, OP_XORI  = 6'd13,
        OP_ORI   = 6'd14, OP_ANDI  = 6'd15,
        OP_SLLI  = 6'd16, OP_SRLI  = 6'd17, OP_SRAI  = 6'd18,
        OP_LB    = 6'd19, OP_LH    = 6'd20, OP_LW    = 6'd21, OP_LBU   = 6'd22,
        OP_LHU   = 6'd23,
        OP_SB    = 6'd24, OP_SH    = 6'd25, OP_SW    = 6'd26,
        OP_BEQ   = 6'd27, OP_BNE   = 6'd28, OP_BLT   = 6'd29, OP_BGE   = 6'd30,
        OP_BLTU  = 6'd31, OP_BGEU  = 6'd32,
        OP_LUI   = 6'd33, OP_AUIPC = 6'd34, OP_JAL   = 6'd35, OP_JALR  = 6'd36
    } op_e;

    // Instruction format classes; FMT_BAD marks an undefined op index.
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SR      = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;
    localparam logic [2:0] F3_B       = 3'd0;
    localparam logic [2:0] F3_H       = 3'd1;
    localparam logic [2:0] F3_W       = 3'd2;
    localparam logic [2:0] F3_BU      = 3'd4;
    localparam logic [2:0] F3_HU      = 3'd5;
    localparam logic [2:0] F3_BEQ     = 3'd0;
    localparam logic [2:0] F3_BNE     = 3'd1;
    localparam logic [2:0] F3_BLT     = 3'd4;
    localparam logic [2:0] F3_BGE     = 3'd5;
    localparam logic [2:0] F3_BLTU    = 3'd6;
    localparam logic [2:0] F3_BGEU    = 3'd7;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } op_info_t;

    function automatic op_info_t mk(fmt_e f, logic [6:0] opc, logic [2:0] f3, logic [6:0] f7);
        op_info_t r;
        r.fmt    = f;
        r.opcode = opc;
        r.funct3 = f3;
        r.funct7 = f7;
        return r;
    endfunction

    // Per-op format and fixed fields; decode inverts this same table.
    function automatic op_info_t op_info(logic [5:0] op);
        op_info_t info;
        info = mk(FMT_BAD, 7'd0, 3'd0, F7_BASE);
        case (op)
            OP_ADD:   info = mk(FMT_R,  OPC_OP,     F3_ADD_SUB, F7_BASE);
            OP_SUB:   info = mk(FMT_R,  OPC_OP,     F3_ADD_SUB, F7_ALT);
            OP_SLL:   info = mk(FMT_R,  OPC_OP,     F3_SLL,     F7_BASE);
            OP_SLT:   info = mk(FMT_R,  OPC_OP,     F3_SLT,     F7_BASE);
            OP_SLTU:  info = mk(FMT_R,  OPC_OP,     F3_SLTU,    F7_BASE);
            OP_XOR:   info = mk(FMT_R,  OPC_OP,     F3_XOR,     F7_BASE);
            OP_SRL:   info = mk(FMT_R,  OPC_OP,     F3_SR,      F7_BASE);
            OP_SRA:   info = mk(FMT_R,  OPC_OP,     F3_SR,      F7_ALT);
            OP_OR:    info = mk(FMT_R,  OPC_OP,     F3_OR,      F7_BASE);
            OP_AND:   info = mk(FMT_R,  OPC_OP,     F3_AND,     F7_BASE);
            OP_ADDI:  info = mk(FMT_I,  OPC_OPIMM,  F3_ADD_SUB, F7_BASE);
            OP_SLTI:  info = mk(FMT_I,  OPC_OPIMM,  F3_SLT,     F7_BASE);
            OP_SLTIU: info = mk(FMT_I,  OPC_OPIMM,  F3_SLTU,    F7_BASE);
            OP_XORI:  info = mk(FMT_I,  OPC_OPIMM,  F3_XOR,     F7_BASE);
            OP_ORI:   info = mk(FMT_I,  OPC_OPIMM,  F3_OR,      F7_BASE);
            OP_ANDI:  info = mk(FMT_I,  OPC_OPIMM,  F3_AND,     F7_BASE);
            OP_SLLI:  info = mk(FMT_SH, OPC_OPIMM,  F3_SLL,     F7_BASE);
            OP_SRLI:  info = mk(FMT_SH, OPC_OPIMM,  F3_SR,      F7_BASE);
            OP_SRAI:  info = mk(FMT_SH, OPC_OPIMM,  F3_SR,      F7_ALT);
            OP_LB:    info = mk(FMT_I,  OPC_LOAD,   F3_B,       F7_BASE);
            OP_LH:    info = mk(FMT_I,  OPC_LOAD,   F3_H,       F7_BASE);
            OP_LW:    info = mk(FMT_I,  OPC_LOAD,   F3_W,       F7_BASE);
            OP_LBU:   info = mk(FMT_I,  OPC_LOAD,   F3_BU,      F7_BASE);
            OP_LHU:   info = mk(FMT_I,  OPC_LOAD,   F3_HU,      F7_BASE);
            OP_SB:    info = mk(FMT_S,  OPC_STORE,  F3_B,       F7_BASE);
            OP_SH:    info = mk(FMT_S,  OPC_STORE,  F3_H,       F7_BASE);
            OP_SW:    info = mk(FMT_S,  OPC_STORE,  F3_W,       F7_BASE);
            OP_BEQ:   info = mk(FMT_B,  OPC_BRANCH, F3_BEQ,     F7_BASE);
            OP_BNE:   info = mk(FMT_B,  OPC_BRANCH, F3_BNE,     F7_BASE);
            OP_BLT:   info = mk(FMT_B,  OPC_BRANCH, F3_BLT,     F7_BASE);
            OP_BGE:   info = mk(FMT_B,  OPC_BRANCH, F3_BGE,     F7_BASE);
            OP_BLTU:  info = mk(FMT_B,  OPC_BRANCH, F3_BLTU,    F7_BASE);
            OP_BGEU:  info = mk(FMT_B,  OPC_BRANCH, F3_BGEU,    F7_BASE);
            OP_LUI:   info = mk(FMT_U,  OPC_LUI,    3'd0,       F7_BASE);
            OP_AUIPC: info = mk(FMT_U,  OPC_AUIPC,  3'd0,       F7_BASE);
            OP_JAL:   info = mk(FMT_J,  OPC_JAL,    3'd0,       F7_BASE);
            OP_JALR:  info = mk(FMT_I,  OPC_JALR,   3'd0,       F7_BASE);
            default:  info = mk(FMT_BAD, 7'd0,      3'd0,       F7_BASE);
        endcase
        return info;
    endfunction

endpackage

// File: rtl/instr_encoder_fifo2.sv
// Two-entry FIFO; storage is unreset, only occupancy and pointers reset.
module fifo2 #(
    parameter int W = 46
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push_ok, pop_ok;

    assign push_ok = push_i && (count_q != 2'd2);
    assign pop_ok  = pop_i && (count_q != 2'd0);

    // Next pointers and occupancy; push+pop together keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = ~wr_ptr_q;
        if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage; contents are don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: combinational encode + range check feeding a
// 2-entry FIFO, with an address stamp pointer and a sticky error capture.
// Handshake: a transfer happens on a rising edge where valid && ready; ready
// never depends combinationally on the same port's valid or on out_ready.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              base_valid,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    output logic [5:0]        err_op,
    input  logic              err_clr
);

    localparam int DW = 32 + ADDR_W;

    op_info_t          info;
    logic [31:0]       enc_instr;
    logic              enc_legal;
    logic              accept, push, pop, reject;
    logic [ADDR_W-1:0] stamp_addr;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              err_q, err_d;
    logic [5:0]        err_op_q, err_op_d;
    logic [DW-1:0]     head;
    logic [1:0]        count;

    // Encode the request into its format and check the immediate range.
    always_comb begin
        info      = op_info(in_op);
        enc_instr = 32'd0;
        enc_legal = 1'b0;
        case (info.fmt)
            FMT_R: begin
                enc_legal = 1'b1;
                enc_instr = {info.funct7, in_rs2, in_rs1, info.funct3, in_rd, info.opcode};
            end
            FMT_I: begin
                enc_legal = (in_imm[31:11] == {21{in_imm[11]}});
                enc_instr = {in_imm[11:0], in_rs1, info.funct3, in_rd, info.opcode};
            end
            FMT_SH: begin
                enc_legal = (in_imm[31:5] == 27'd0);
                enc_instr = {info.funct7, in_imm[4:0], in_rs1, info.funct3, in_rd, info.opcode};
            end
            FMT_S: begin
                enc_legal = (in_imm[31:11] == {21{in_imm[11]}});
                enc_instr = {in_imm[11:5], in_rs2, in_rs1, info.funct3, in_imm[4:0], info.opcode};
            end
            FMT_B: begin
                enc_legal = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
                enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, info.funct3,
                             in_imm[4:1], in_imm[11], info.opcode};
            end
            FMT_U: begin
                enc_legal = (in_imm[11:0] == 12'd0);
                enc_instr = {in_imm[31:12], in_rd, info.opcode};
            end
            FMT_J: begin
                enc_legal = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
                enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                             in_rd, info.opcode};
            end
            default: begin
                enc_legal = 1'b0;
                enc_instr = 32'd0;
            end
        endcase
    end

    assign in_ready   = (count < 2'd2);
    assign out_valid  = (count != 2'd0);
    assign accept     = in_valid && in_ready;
    assign push       = accept && enc_legal;
    assign reject     = accept && !enc_legal;
    assign pop        = out_valid && out_ready;
    // A coincident base load takes effect for this push already.
    assign stamp_addr = base_valid ? base_addr : wptr_q;

    // Pointer advance and sticky error capture; a new error beats err_clr.
    always_comb begin
        wptr_d   = wptr_q;
        err_d    = err_q;
        err_op_d = err_op_q;
        if (push)            wptr_d = stamp_addr + ADDR_W'(1);
        else if (base_valid) wptr_d = base_addr;
        if (reject) begin
            err_d = 1'b1;
            if (!err_q || err_clr) err_op_d = in_op;
        end else if (err_clr) begin
            err_d    = 1'b0;
            err_op_d = 6'd0;
        end
    end

    // Pointer and error registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            err_q    <= 1'b0;
            err_op_q <= 6'd0;
        end else begin
            wptr_q   <= wptr_d;
            err_q    <= err_d;
            err_op_q <= err_op_d;
        end
    end

    fifo2 #(.W(DW)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({enc_instr, stamp_addr}),
        .rdata_o (head),
        .count_o (count)
    );

    assign out_instr = head[DW-1 -: 32];
    assign out_addr  = head[ADDR_W-1:0];
    assign err       = err_q;
    assign err_op    = err_op_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios then random traffic, checked
// every cycle against a behavioural model built from the RV32I field layout.
module tb_instr_encoder;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          base_valid;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_op;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;
  logic [5:0]    err_op;
  logic          err_clr;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .base_valid(base_valid), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_op(err_op), .err_clr(err_clr)
  );

  localparam int ADDI = 10, SW = 26, BEQ = 27, LUI = 33, JAL = 35;

  int total = 0;
  int bad   = 0;

  // scoreboard: {instr, addr} in push order
  logic [31+AW:0] exp_q[$];
  logic [AW-1:0]  m_ptr = '0;
  logic           m_err = 1'b0;
  logic [5:0]     m_err_op = 6'd0;

  int f3_tab[37] = '{0,0,1,2,3,4,5,5,6,7, 0,2,3,4,6,7, 1,5,5, 0,1,2,4,5,
                     0,1,2, 0,1,4,5,6,7, 0,0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference encoding from the RV32I field layout with plain arithmetic.
  function automatic void model_enc(input int op, input logic [4:0] rd5, input logic [4:0] rs15,
                                    input logic [4:0] rs25, input logic [31:0] imm,
                                    output bit ok, output logic [31:0] w);
    int s;
    logic [31:0] d, a, b, f3, f7;
    s  = $signed(imm);
    d  = 32'(rd5) << 7;
    a  = 32'(rs15) << 15;
    b  = 32'(rs25) << 20;
    f3 = (op < 37) ? (32'(f3_tab[op]) << 12) : 32'd0;
    ok = 1'b0;
    w  = 32'd0;
    if (op <= 9) begin
      f7 = (op == 1 || op == 7) ? 32'h20 : 32'h0;
      ok = 1'b1;
      w  = (f7 << 25) | b | a | f3 | d | 32'h33;
    end else if (op <= 15 || (op >= 19 && op <= 23) || op == 36) begin
      ok = (s >= -2048) && (s <= 2047);
      w  = ((imm & 32'hFFF) << 20) | a | f3 | d |
           ((op <= 15) ? 32'h13 : (op == 36) ? 32'h67 : 32'h03);
    end else if (op <= 18) begin
      f7 = (op == 18) ? 32'h20 : 32'h0;
      ok = (s >= 0) && (s <= 31);
      w  = (f7 << 25) | ((imm & 32'h1F) << 20) | a | f3 | d | 32'h13;
    end else if (op <= 26) begin
      ok = (s >= -2048) && (s <= 2047);
      w  = (((imm >> 5) & 32'h7F) << 25) | b | a | f3 | ((imm & 32'h1F) << 7) | 32'h23;
    end else if (op <= 32) begin
      ok = (s >= -4096) && (s <= 4094) && (s % 2 == 0);
      w  = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | b | a | f3 |
           (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
    end else if (op <= 34) begin
      ok = ((imm & 32'hFFF) == 0);
      w  = (imm & 32'hFFFFF000) | d | ((op == 33) ? 32'h37 : 32'h17);
    end else if (op == 35) begin
      ok = (s >= -1048576) && (s <= 1048574) && (s % 2 == 0);
      w  = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
           (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | 32'h6F;
    end
  endfunction

  task automatic drive(input bit v, input int op, input logic [4:0] rd5, input logic [4:0] rs15,
                       input logic [4:0] rs25, input logic [31:0] imm);
    in_valid = v;
    in_op    = 6'(op);
    in_rd    = rd5;
    in_rs1   = rs15;
    in_rs2   = rs25;
    in_imm   = imm;
  endtask

  // Check outputs against the model, advance the model, then clock once.
  task automatic cycle(output bit accepted);
    bit             ok, pop;
    logic [31:0]    w;
    logic [AW-1:0]  stamp;
    logic [31+AW:0] hd;
    #1;
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      hd = exp_q[0];
      chk("out_instr", 64'(out_instr), 64'(hd[31+AW:AW]));
      chk("out_addr", 64'(out_addr), 64'(hd[AW-1:0]));
    end
    chk("err", 64'(err), 64'(m_err));
    chk("err_op", 64'(err_op), 64'(m_err_op));
    accepted = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      m_ptr    = '0;
      m_err    = 1'b0;
      m_err_op = 6'd0;
    end else begin
      accepted = in_valid && (exp_q.size() < 2);
      pop      = (exp_q.size() != 0) && out_ready;
      model_enc(int'(in_op), in_rd, in_rs1, in_rs2, in_imm, ok, w);
      stamp    = base_valid ? base_addr : m_ptr;
      if (pop) void'(exp_q.pop_front());
      if (accepted && ok) begin
        exp_q.push_back({w, stamp});
        m_ptr = stamp + AW'(1);
      end else if (base_valid) begin
        m_ptr = base_addr;
      end
      if (accepted && !ok) begin
        if (!m_err || err_clr) m_err_op = in_op;
        m_err = 1'b1;
      end else if (err_clr) begin
        m_err    = 1'b0;
        m_err_op = 6'd0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    logic [31:0] imm;
    rst_n = 1'b0; base_valid = 1'b0; base_addr = '0; out_ready = 1'b0; err_clr = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    cycle(acc);
    rst_n = 1'b1;

    // single legal requests, one cycle latency
    out_ready = 1'b1;
    drive(1, ADDI, 1, 0, 0, 32'd5);          cycle(acc);
    chk("addi_instr", 64'(out_instr), 64'h00500093);
    chk("addi_addr", 64'(out_addr), 64'd0);
    drive(1, SW, 0, 1, 2, 32'd8);            cycle(acc);
    chk("sw_instr", 64'(out_instr), 64'h0020A423);
    chk("sw_addr", 64'(out_addr), 64'd1);
    drive(1, LUI, 5, 0, 0, 32'h12345000);    cycle(acc);
    chk("lui_instr", 64'(out_instr), 64'h123452B7);
    drive(1, JAL, 1, 0, 0, 32'd8);           cycle(acc);
    chk("jal_instr", 64'(out_instr), 64'h008000EF);

    // odd branch offset rejected, then cleared by a following legal request
    drive(1, BEQ, 0, 1, 2, 32'd3);           cycle(acc);
    chk("beq_err", 64'(err), 64'd1);
    chk("beq_err_op", 64'(err_op), 64'(BEQ));
    chk("beq_no_push", 64'(out_valid), 64'd0);
    err_clr = 1'b1;
    drive(1, ADDI, 1, 0, 0, 32'd5);          cycle(acc);
    err_clr = 1'b0;
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_addr", 64'(out_addr), 64'd4);
    drive(0, 0, 0, 0, 0, 0);                 cycle(acc);

    // backpressure: two accepts fill the FIFO, third waits
    rst_n = 1'b0;                            cycle(acc);
    rst_n = 1'b1;
    out_ready = 1'b0;
    drive(1, ADDI, 1, 0, 0, 32'd1);          cycle(acc);
    drive(1, ADDI, 1, 0, 0, 32'd2);          cycle(acc);
    drive(1, ADDI, 1, 0, 0, 32'd3);
    chk("full_ready", 64'(in_ready), 64'd0);
    chk("full_head", 64'(out_instr), 64'h00100093);
    chk("full_addr0", 64'(out_addr), 64'd0);
    cycle(acc);
    out_ready = 1'b1;                        cycle(acc);
    chk("drain_addr1", 64'(out_addr), 64'd1);
    cycle(acc);
    chk("drain_addr2", 64'(out_addr), 64'd2);
    chk("third_instr", 64'(out_instr), 64'h00300093);
    drive(0, 0, 0, 0, 0, 0);                 cycle(acc);

    // base load coincident with a push, then pointer wrap
    base_valid = 1'b1; base_addr = 14'h3FFF;
    drive(1, ADDI, 2, 3, 0, 32'd7);          cycle(acc);
    base_valid = 1'b0;
    chk("base_addr", 64'(out_addr), 64'h3FFF);
    drive(1, ADDI, 2, 3, 0, 32'd9);          cycle(acc);
    chk("wrap_addr", 64'(out_addr), 64'h0);

    // reset mid-stream with two entries queued and err set
    out_ready = 1'b0;
    drive(1, 63, 0, 0, 0, 0);                cycle(acc);
    drive(1, ADDI, 1, 1, 0, 32'd1);          cycle(acc);
    drive(1, ADDI, 1, 1, 0, 32'd2);          cycle(acc);
    drive(0, 0, 0, 0, 0, 0);
    chk("pre_rst_err", 64'(err), 64'd1);
    rst_n = 1'b0;                            cycle(acc);
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    drive(1, ADDI, 1, 0, 0, 32'd5);          cycle(acc);
    chk("rst_addr", 64'(out_addr), 64'd0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 4))
        0: imm = 32'($urandom_range(0, 40));
        1: imm = -32'($urandom_range(0, 5000));
        2: imm = $urandom() & 32'hFFFFF000;
        3: imm = 32'(int'($urandom_range(0, 4000000)) - 2000000);
        default: imm = $urandom();
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 40), 5'($urandom()),
            5'($urandom()), 5'($urandom()), imm);
      rst_n      = ($urandom_range(0, 99) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      base_valid = ($urandom_range(0, 19) == 0);
      base_addr  = AW'($urandom());
      err_clr    = ($urandom_range(0, 19) == 0);
      cycle(acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, width of the IMEM word address.
REQ-002 SHALL have ports as follows; there is one clock, and reset is synchronous and active-low.
  clk        input   1       sole clock; all state updates on its rising edge
  rst_n      input   1       synchronous, active-low reset
  base_valid input   1       load the write pointer from base_addr
  base_addr  input   ADDR_W  new write-pointer value
  in_valid   input   1       request valid
  in_ready   output  1       request accepted when in_valid && in_ready
  in_op      input   6       op index; shared enumeration with the decode stage (ADD..JALR)
  in_rd      input   5       destination register
  in_rs1     input   5       source register 1
  in_rs2     input   5       source register 2
  in_imm     input   32      immediate, two's complement, unshifted byte value
  out_valid  output  1       encoded word valid
  out_ready  input   1       consumer accepts when out_valid && out_ready
  out_instr  output  32      encoded RV32I instruction
  out_addr   output  ADDR_W  IMEM word address for out_instr
  err        output  1       sticky error flag
  err_op     output  6       in_op of the first rejected request
  err_clr    input   1       clears err and err_op

Function
REQ-003 SHALL encode each accepted request into the RV32I format of its op: R, I, I-shift, S, B, U or J; opcode, funct3 and funct7 SHALL be the exact inverse of the decode stage.
REQ-004 Shift immediates SHALL use imm[4:0]; SRAI SHALL use funct7 0100000; SLLI and SRLI SHALL use funct7 0000000.
REQ-005 The immediate SHALL be legal only if it is in range:
  - I and S types: -2048..2047
  - B type: -4096..4094 and even
  - J type: -1048576..1048574 and even
  - U type: imm[11:0]==0
  - shifts: 0..31
REQ-006 An undefined op index, or an out-of-range immediate, SHALL be accepted (consumed) but not pushed, and SHALL set err.
REQ-007 err_op SHALL capture in_op only when err was clear; later errors SHALL NOT overwrite it.
REQ-008 err_clr SHALL clear err and err_op to 0 on the next edge; if a new error occurs in the same cycle, the new error SHALL win.
REQ-009 The block SHALL contain a 2-entry output FIFO; each entry SHALL hold {instr, addr}.
REQ-010 in_ready SHALL equal (FIFO count < 2) and SHALL NOT depend combinationally on out_ready.
REQ-011 A legal request accepted at edge N SHALL be visible on out_valid/out_instr in the cycle after edge N (1-cycle latency).
REQ-012 A simultaneous push and pop SHALL leave the FIFO count unchanged; output order SHALL be strict FIFO.
REQ-013 out_valid SHALL equal (FIFO count != 0); out_instr and out_addr SHALL come from the head entry.
REQ-014 The write pointer SHALL be stamped into each pushed entry and then increment by 1, wrapping modulo 2^ADDR_W.
REQ-015 Rejected requests SHALL NOT advance the write pointer.
REQ-016 base_valid SHALL load the pointer; if a push occurs in the same cycle, that push SHALL use base_addr and the pointer SHALL become base_addr+1.
REQ-017 Entries already queued SHALL keep their stamped addresses.
REQ-018 Sustained throughput SHALL be 1 word/cycle while out_ready is held high.

Reset
REQ-019 While rst_n==0 at a clock edge, the following SHALL be cleared:
  - FIFO count, so out_valid=0
  - write pointer to 0
  - err and err_op to 0
REQ-020 Reset asserted mid-stream SHALL discard queued entries; in_ready SHALL be 1 in the first cycle after reset release.
REQ-021 FIFO data storage SHALL need no reset; out_instr and out_addr are don't-care while out_valid=0.

Structure
REQ-022 The op-index enumeration, the 7-bit opcodes, and the funct3/funct7 constants SHALL live in one shared package, also used by the decode stage.
REQ-023 The 2-entry FIFO SHALL be a separate sub-module named fifo2, parameterised by data width.
REQ-024 Encoding and range checking SHALL be combinational logic ahead of the FIFO write port.

Verification
REQ-025 Single legal requests with out_ready=1 SHALL produce the following, each one cycle after acceptance:
  - ADDI rd=1 rs1=0 imm=5 -> out_instr 0x00500093, out_addr 0
  - SW rs2=2 rs1=1 imm=8 -> 0x0020A423, out_addr 1
  - LUI rd=5 imm=0x12345000 -> 0x123452B7
  - JAL rd=1 imm=8 -> 0x008000EF
REQ-026 BEQ imm=3 (odd) -> no push, err=1, err_op=BEQ index, pointer unchanged; a following ADDI with err_clr=1 -> err=0, word emitted.
REQ-027 With out_ready=0, three back-to-back requests -> in_ready falls after 2 accepts; raising out_ready drains them in order at addrs 0,1; the third is then accepted at addr 2.
REQ-028 base_valid with base_addr=2^ADDR_W-1, coincident with a push, followed by a second push -> addrs 0x3FFF then 0x0000 (wrap).
REQ-029 rst_n=0 for one cycle while 2 entries are queued -> out_valid=0, err=0 and in_ready=1 next cycle; the next push gets addr 0.
